operand_entry: RTL and testbench

OPERAND_ENTRY -- requirements
Module: operand_entry

---
 rtl/operand_entry.sv | 160 ++++++++++++++++
 tb/tb_operand_entry.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_entry.sv
// Push-button operand entry: debounced 5-button keypad edits a signed BCD
// operand, converts it to two's complement and writes it over a valid/ready port.
module operand_entry #(
    parameter int NUM_DIGITS   = 4,
    parameter int NUM_OPERANDS = 2,
    parameter int DATA_W       = 16,
    parameter int DEB_CYCLES   = 1000000,
    localparam int CW = $clog2(NUM_DIGITS + 1),
    localparam int AW = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    btn_c,
    input  logic                    btn_u,
    input  logic                    btn_l,
    input  logic                    btn_r,
    input  logic                    btn_d,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    sign,
    output logic [CW-1:0]           cursor,
    output logic [AW-1:0]           operand_sel,
    output logic                    busy,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [AW-1:0]           wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    output logic                    all_done
);

    localparam int DBW = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {
        EDIT,
        CONVERT,
        WRITE
    } state_t;

    // Button vector order doubles as priority order: C, L, R, U, D
    logic [4:0]     raw;
    logic [4:0]     sync1, sync2, deb, deb_d;
    logic [DBW-1:0] deb_cnt [5];
    logic [4:0]     press;

    state_t         state;
    logic [3:0]     dig [NUM_DIGITS];
    logic [DATA_W-1:0] acc, acc_next;
    logic [CW-1:0]  conv_idx;
    logic [3:0]     conv_digit;

    assign raw   = {btn_d, btn_u, btn_r, btn_l, btn_c};
    assign press = deb & ~deb_d;
    assign busy  = (state != EDIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int unsigned i = 0; i < 5; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            for (int unsigned i = 0; i < 5; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (deb_cnt[i] == DBW'(DEB_CYCLES - 1)) begin
                        deb[i]     <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DBW'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        conv_digit = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++)
            if (conv_idx == CW'(i)) conv_digit = dig[i];
        acc_next = acc * DATA_W'(10) + DATA_W'(conv_digit);
    end

    always_comb begin
        digits = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++)
            digits[4*i +: 4] = dig[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= EDIT;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) dig[i] <= '0;
            sign        <= 1'b0;
            cursor      <= '0;
            operand_sel <= '0;
            acc         <= '0;
            conv_idx    <= '0;
            wr_valid    <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            all_done    <= 1'b0;
        end else begin
            all_done <= 1'b0;
            unique case (state)
                EDIT: begin
                    if (press[0]) begin
                        state    <= CONVERT;
                        acc      <= '0;
                        conv_idx <= CW'(NUM_DIGITS - 1);
                    end else if (press[1]) begin
                        cursor <= (cursor == CW'(NUM_DIGITS)) ? '0 : cursor + CW'(1);
                    end else if (press[2]) begin
                        cursor <= (cursor == '0) ? CW'(NUM_DIGITS) : cursor - CW'(1);
                    end else if (press[3] || press[4]) begin
                        if (cursor == CW'(NUM_DIGITS)) begin
                            sign <= ~sign;
                        end else begin
                            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                                if (cursor == CW'(i)) begin
                                    if (press[3]) dig[i] <= (dig[i] == 4'd9) ? 4'd0 : dig[i] + 4'd1;
                                    else          dig[i] <= (dig[i] == 4'd0) ? 4'd9 : dig[i] - 4'd1;
                                end
                            end
                        end
                    end
                end
                CONVERT: begin
                    // MSD first; the final step lands directly in the write registers
                    acc <= acc_next;
                    if (conv_idx == '0) begin
                        state    <= WRITE;
                        wr_valid <= 1'b1;
                        wr_addr  <= operand_sel;
                        wr_data  <= sign ? -acc_next : acc_next;
                    end else begin
                        conv_idx <= conv_idx - CW'(1);
                    end
                end
                WRITE: begin
                    if (wr_ready) begin
                        state    <= EDIT;
                        wr_valid <= 1'b0;
                        for (int unsigned i = 0; i < NUM_DIGITS; i++) dig[i] <= '0;
                        sign     <= 1'b0;
                        cursor   <= '0;
                        all_done <= (operand_sel == AW'(NUM_OPERANDS - 1));
                        operand_sel <= (operand_sel == AW'(NUM_OPERANDS - 1)) ? '0
                                       : operand_sel + AW'(1);
                    end
                end
                default: state <= EDIT;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_entry.sv
// Scoreboard bench for operand_entry: arithmetic model of the keypad editor,
// expected writes queued at stimulus time, popped by an independent monitor.
module tb_operand_entry;

    localparam int N   = 4;
    localparam int NO  = 2;
    localparam int DW  = 16;
    localparam int DEB = 4;
    localparam int CW  = 3;
    localparam int AW  = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          btn_c = 1'b0, btn_u = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_d = 1'b0;
    logic          wr_ready = 1'b0;
    logic [4*N-1:0] digits;
    logic          sign;
    logic [CW-1:0] cursor;
    logic [AW-1:0] operand_sel;
    logic          busy;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          all_done;

    operand_entry #(
        .NUM_DIGITS  (N),
        .NUM_OPERANDS(NO),
        .DATA_W      (DW),
        .DEB_CYCLES  (DEB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_c      (btn_c),
        .btn_u      (btn_u),
        .btn_l      (btn_l),
        .btn_r      (btn_r),
        .btn_d      (btn_d),
        .digits     (digits),
        .sign       (sign),
        .cursor     (cursor),
        .operand_sel(operand_sel),
        .busy       (busy),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .all_done   (all_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;

    // Reference model: plain integers per digit
    int md[N];
    int msign = 0, mcur = 0, msel = 0;
    int ready_mode = 2;   // 0 random, 1 held low, 2 held high
    int last_wr_data = -1;

    localparam logic [4:0] B_C = 5'b00001;
    localparam logic [4:0] B_L = 5'b00010;
    localparam logic [4:0] B_R = 5'b00100;
    localparam logic [4:0] B_U = 5'b01000;
    localparam logic [4:0] B_D = 5'b10000;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, req, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int model_digits();
        int e = 0;
        for (int i = 0; i < N; i++) e = e + (md[i] << (4 * i));
        return e;
    endfunction

    task automatic model_clear_entry();
        for (int i = 0; i < N; i++) md[i] = 0;
        msign = 0;
        mcur  = 0;
    endtask

    task automatic check_display();
        chk("digits",      int'(digits),      model_digits());
        chk("sign",        int'(sign),        msign);
        chk("cursor",      int'(cursor),      mcur);
        chk("operand_sel", int'(operand_sel), msel);
        chk("busy_idle",   int'(busy),        0);
        chk("wr_valid_idle", int'(wr_valid),  0);
    endtask

    // Returns 1 when the press is a conversion request
    function automatic bit model_apply(input logic [4:0] mask);
        int mag;
        int val;
        wr_t w;
        if (mask[0]) begin
            mag = 0;
            for (int i = 0; i < N; i++) mag = mag + md[i] * (10 ** i);
            val = msign ? -mag : mag;
            w.addr = msel;
            w.data = val & 32'hFFFF;
            exp_q.push_back(w);
            return 1'b1;
        end else if (mask[1]) begin
            mcur = (mcur + 1) % (N + 1);
        end else if (mask[2]) begin
            mcur = (mcur + N) % (N + 1);
        end else if (mask[3] || mask[4]) begin
            if (mcur == N) msign = 1 - msign;
            else if (mask[3]) md[mcur] = (md[mcur] + 1) % 10;
            else              md[mcur] = (md[mcur] + 9) % 10;
        end
        return 1'b0;
    endfunction

    task automatic finish_write();
        int n = 0;
        while (busy && n < 100) begin
            tick(1);
            n++;
        end
        chk("idle_timeout", int'(busy), 0);
        if (!busy) begin
            model_clear_entry();
            msel = (msel + 1) % NO;
        end
        check_display();
    endtask

    task automatic press(input logic [4:0] mask, input bit wait_idle);
        bit was_busy;
        bit is_c;
        was_busy = busy;
        is_c = 1'b0;
        {btn_d, btn_u, btn_r, btn_l, btn_c} = mask;
        if (!was_busy) is_c = model_apply(mask);
        if (is_c) begin
            // 2 sync + DEB debounce edges to the pulse, then N+1 to wr_valid
            tick(DEB + N + 2);
            chk("latency_early", int'(wr_valid), 0);
            tick(1);
            chk("latency_valid", int'(wr_valid), 1);
        end else begin
            tick(DEB + N + 3);
        end
        {btn_d, btn_u, btn_r, btn_l, btn_c} = 5'b0;
        tick(DEB + 4);
        if (wait_idle) begin
            if (is_c) finish_write();
            else      check_display();
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) wr_ready = ($urandom_range(0, 2) != 0);
        else                 wr_ready = (ready_mode == 2);
    end

    // Monitor: scoreboard pops, all_done pulse and WRITE stability
    int  hs_prev = 0, hs_prev_addr = 0;
    int  last_valid = 0, last_data = 0, last_addr = 0;
    always @(negedge clk) begin
        int hs_now;
        wr_t w;
        if (reset) begin
            hs_prev = 0;
            last_valid = 0;
        end else begin
            chk("all_done", int'(all_done), (hs_prev != 0 && hs_prev_addr == NO - 1) ? 1 : 0);
            if (wr_valid) chk("busy_in_write", int'(busy), 1);
            if (last_valid != 0 && hs_prev == 0) begin
                chk("hold_wr_valid", int'(wr_valid), 1);
                chk("hold_wr_data",  int'(wr_data),  last_data);
                chk("hold_wr_addr",  int'(wr_addr),  last_addr);
            end
            hs_now = (wr_valid && wr_ready) ? 1 : 0;
            if (hs_now != 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    chk("wr_addr", int'(wr_addr), w.addr);
                    chk("wr_data", int'(wr_data), w.data);
                end
                last_wr_data = int'(wr_data);
            end
            hs_prev      = hs_now;
            hs_prev_addr = int'(wr_addr);
            last_valid   = int'(wr_valid);
            last_data    = int'(wr_data);
            last_addr    = int'(wr_addr);
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_digits"},   int'(digits),      0);
        chk({tag, "_sign"},     int'(sign),        0);
        chk({tag, "_cursor"},   int'(cursor),      0);
        chk({tag, "_sel"},      int'(operand_sel), 0);
        chk({tag, "_busy"},     int'(busy),        0);
        chk({tag, "_wr_valid"}, int'(wr_valid),    0);
        chk({tag, "_wr_addr"},  int'(wr_addr),     0);
        chk({tag, "_wr_data"},  int'(wr_data),     0);
        chk({tag, "_all_done"}, int'(all_done),    0);
    endtask

    initial begin
        logic [4:0] m;
        int r;
        for (int i = 0; i < N; i++) md[i] = 0;

        #1 reset = 1'b1;
        #1 check_reset_values("reset");
        tick(2);
        reset = 1'b0;
        check_display();

        // 1234 into operand 0
        repeat (4) press(B_U, 1);
        press(B_L, 1);
        repeat (3) press(B_U, 1);
        press(B_L, 1);
        repeat (2) press(B_U, 1);
        press(B_L, 1);
        press(B_U, 1);
        chk("entered_1234", int'(digits), 16'h1234);
        press(B_C, 1);
        chk("value_1234", last_wr_data, 16'h04D2);
        chk("sel_after_first", int'(operand_sel), 1);

        // -7 into operand 1
        press(B_R, 1);
        chk("cursor_wrap_to_sign", int'(cursor), 4);
        press(B_U, 1);
        chk("sign_set", int'(sign), 1);
        press(B_L, 1);
        repeat (7) press(B_U, 1);
        press(B_C, 1);
        chk("value_neg7", last_wr_data, 16'hFFF9);
        chk("sel_wrap", int'(operand_sel), 0);

        // digit wrap without carry/borrow, then negative zero
        repeat (9) press(B_U, 1);
        press(B_L, 1);
        repeat (2) press(B_U, 1);
        press(B_R, 1);
        press(B_U, 1);
        chk("wrap_9_to_0", int'(digits), 16'h0020);
        press(B_D, 1);
        chk("wrap_0_to_9", int'(digits), 16'h0029);
        press(B_C, 1);
        press(B_R, 1);
        press(B_U, 1);
        press(B_C, 1);
        chk("neg_zero", last_wr_data, 16'h0000);

        // short glitch rejected, long hold gives one increment
        btn_u = 1'b1;
        tick(3);
        btn_u = 1'b0;
        tick(10);
        check_display();
        btn_u = 1'b1;
        tick(20);
        btn_u = 1'b0;
        tick(DEB + 4);
        md[mcur] = (md[mcur] + 1) % 10;
        check_display();

        // stalled write ignores buttons, then both operands complete
        ready_mode = 1;
        press(B_C, 0);
        press(B_U, 0);
        tick(10);
        chk("stall_valid", int'(wr_valid), 1);
        chk("stall_busy",  int'(busy),     1);
        chk("stall_digits", int'(digits),  model_digits());
        ready_mode = 2;
        finish_write();
        press(B_L, 1);
        press(B_U, 1);
        press(B_C, 1);
        chk("sel_after_pair", int'(operand_sel), 0);

        // reset while a write is pending
        ready_mode = 1;
        press(B_U, 1);
        press(B_C, 0);
        chk("pending_valid", int'(wr_valid), 1);
        #2 reset = 1'b1;
        #1 check_reset_values("reset_in_write");
        exp_q.delete();
        model_clear_entry();
        msel = 0;
        tick(2);
        reset = 1'b0;
        ready_mode = 2;
        tick(3);
        check_display();

        // button held across reset release
        reset = 1'b1;
        btn_u = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(DEB + 2);
        chk("held_reset_before", int'(digits), 0);
        tick(1);
        chk("held_reset_after", int'(digits), 1);
        btn_u = 1'b0;
        tick(DEB + 4);
        md[0] = 1;
        check_display();

        // randomized editing with random write back-pressure
        ready_mode = 0;
        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 15);
            if (r == 0) begin
                m = B_C;
            end else if (r == 1) begin
                m = 5'($urandom_range(1, 31));
            end else begin
                case ($urandom_range(0, 3))
                    0: m = B_L;
                    1: m = B_R;
                    2: m = B_U;
                    default: m = B_D;
                endcase
            end
            press(m, 1);
        end

        ready_mode = 2;
        tick(5);
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
